// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding.
// Other UI blocks decode busy/state from this same encoding.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } btn_state_e;

endpackage

// File: rtl/button_event_decoder_btn_edge_detect.sv
// Registers the previous level sample and produces single-cycle rise/fall strobes.
// Reusable for any level that is already synchronous to clk (buttons, switches).
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= level;
  end

  assign rise = level & ~btn_q;
  assign fall = ~level & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle UI events: press, release,
// short press, long press, auto-repeat and double click.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic busy
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      longint'(LONG_CYCLES) >= CNT_LIMIT || longint'(GAP_CYCLES) >= CNT_LIMIT ||
      longint'(REPEAT_CYCLES) >= CNT_LIMIT) begin : g_bad_params
    $error("button_event_decoder: timing parameters out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             rise;
  logic             fall;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;

  btn_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  // NOTE: control registers get an async reset so a reset mid-hold drops all pending events at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS1: begin
          if (!btn_level) begin
            state <= GAP;
            cnt   <= CNT_W'(1);
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (btn_level) begin
            state <= PRESS2;
            cnt   <= CNT_W'(1);
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESS2: begin
          // Holding the second press turns the first click into a short press.
          if (!btn_level) begin
            state        <= IDLE;
            cnt          <= '0;
            double_click <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state       <= LONG;
            cnt         <= '0;
            short_press <= 1'b1;
            long_press  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!btn_level) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REPEAT_LAST) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          press_pulse   <= 1'b0;
          release_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
